// File: rtl/tt_pkg.sv
// Shared types and helpers for the truth-table sweep checker.
package tt_pkg;

    // Default gate width and the truth-table width derived from it
    localparam int N_IN_DEF = 4;
    localparam int TT_W_DEF = 2 ** N_IN_DEF;

    // Sweep controller states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } tt_state_t;

    // Bit-reversal of the low n bits of j: result[i] = j[n-1-i], so that
    // netlist input _0 carries the MSB of the sweep index.
    function automatic logic [31:0] idx_to_vec(input logic [31:0] j, input int n);
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < n; i++) begin
            v = (v << 1) | ((j >> i) & 32'd1);
        end
        return v;
    endfunction

    // Truth-table bit that holds the result for index j (MSB-first word)
    function automatic logic [31:0] tt_bit_pos(input logic [31:0] j, input int tt_w);
        return 32'(tt_w - 1) - j;
    endfunction

endpackage

// File: rtl/tt_sweep_checker.sv
// Exhaustive truth-table sweep: drives every input vector into a gate,
// assembles the observed MSB-first truth-table word and compares it with
// an expected word, reporting match, mismatch count and first failing index.
//
// Handshake: start is a single-cycle request that is taken only while the
// controller is IDLE (busy low); a start seen in RUN or DONE is dropped, not
// queued. Completion is the one-cycle done pulse; results stay stable until
// the next accepted start or reset.
module tt_sweep_checker
    import tt_pkg::*;
#(
    parameter int N_IN   = N_IN_DEF,
    parameter int TT_W   = 2 ** N_IN,
    parameter int SETTLE = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [TT_W-1:0]   expected,
    output logic [N_IN-1:0]   dut_in,
    input  logic              dut_out,
    output logic              busy,
    output logic              done,
    output logic              match,
    output logic [TT_W-1:0]   captured,
    output logic [N_IN:0]     mism_cnt,
    output logic [N_IN-1:0]   first_fail,
    output tt_state_t         dbg_state
);

    // Wait counter is at least one bit wide even when SETTLE is 0
    localparam int WC_W = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
    localparam logic [WC_W-1:0] WC_SETTLE = WC_W'(SETTLE);

    tt_state_t         r_state;
    tt_state_t         w_next;
    logic [N_IN-1:0]   r_j;
    logic [WC_W-1:0]   r_wcnt;
    logic [TT_W-1:0]   r_exp_q;
    logic [TT_W-1:0]   r_cap;
    logic [N_IN:0]     r_mism;
    logic [N_IN-1:0]   r_ff;
    logic              r_match;
    logic [N_IN-1:0]   r_dut_in;

    logic              w_sample;
    logic              w_last;
    logic              w_miss;
    logic [N_IN-1:0]   w_pos;
    logic [N_IN-1:0]   w_j_inc;
    logic [N_IN:0]     w_mism_nxt;

    // Sample strobe, expected-bit lookup and next mismatch count
    always_comb begin
        w_sample   = (r_state == RUN) && (r_wcnt == '0);
        w_last     = (r_j == N_IN'(TT_W - 1));
        w_j_inc    = r_j + 1'b1;
        w_pos      = N_IN'(tt_bit_pos(32'(r_j), TT_W));
        w_miss     = w_sample && (dut_out != r_exp_q[w_pos]);
        w_mism_nxt = r_mism + {{N_IN{1'b0}}, w_miss};
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Next-state decode and status outputs
    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) w_next = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (w_sample && w_last) w_next = DONE;
            end
            DONE: begin
                busy   = 1'b1;
                done   = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Sweep index, settle counter, vector drive and result accumulation
    always_ff @(posedge clk) begin
        if (rst) begin
            r_j      <= '0;
            r_wcnt   <= '0;
            r_exp_q  <= '0;
            r_cap    <= '0;
            r_mism   <= '0;
            r_ff     <= '0;
            r_match  <= 1'b0;
            r_dut_in <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_exp_q  <= expected;
                        r_cap    <= '0;
                        r_mism   <= '0;
                        r_ff     <= '0;
                        r_match  <= 1'b0;
                        r_j      <= '0;
                        r_dut_in <= N_IN'(idx_to_vec(32'd0, N_IN));
                        r_wcnt   <= WC_SETTLE;
                    end
                end
                RUN: begin
                    if (r_wcnt != '0) begin
                        r_wcnt <= r_wcnt - 1'b1;
                    end else begin
                        r_cap  <= {r_cap[TT_W-2:0], dut_out};
                        r_mism <= w_mism_nxt;
                        if (w_miss && (r_mism == '0)) r_ff <= r_j;
                        if (w_last) begin
                            // Final compare is already folded into w_mism_nxt
                            r_match <= (w_mism_nxt == '0);
                        end else begin
                            r_j      <= w_j_inc;
                            r_dut_in <= N_IN'(idx_to_vec(32'(w_j_inc), N_IN));
                            r_wcnt   <= WC_SETTLE;
                        end
                    end
                end
                DONE: begin
                    // Return the gate inputs to all-zero for the idle period
                    r_dut_in <= '0;
                end
                default: ;
            endcase
        end
    end

    assign dut_in     = r_dut_in;
    assign match      = r_match;
    assign captured   = r_cap;
    assign mism_cnt   = r_mism;
    assign first_fail = r_ff;
    assign dbg_state  = r_state;

endmodule
